// File: rtl/micro_motor_pkg.sv
// Shared definitions for the motor controller command path.
// Holds the strobe FSM encoding and the controller's command field layout.
package micro_motor_pkg;

   localparam int CMD_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_GAP    = 2'd3
   } strobe_state_t;

   // Field positions already decoded by the system controller.
   localparam int SECTION_MSB = 31;
   localparam int SECTION_LSB = 30;
   localparam int SELECT_MSB  = 29;
   localparam int SELECT_LSB  = 26;
   localparam int MASK_MSB    = 25;
   localparam int MASK_LSB    = 23;

   function automatic logic [CMD_W-1:0] make_cmd(input logic [1:0]  section,
                                                 input logic [3:0]  sel,
                                                 input logic [2:0]  mask,
                                                 input logic [22:0] payload);
      logic [CMD_W-1:0] c;
      c = '0;
      c[SECTION_MSB:SECTION_LSB] = section;
      c[SELECT_MSB:SELECT_LSB]   = sel;
      c[MASK_MSB:MASK_LSB]       = mask;
      c[MASK_LSB-1:0]            = payload;
      return c;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with flush; the head entry is visible without a pop.
// next_level exposes the post-edge occupancy so the owner can register status flags.
module cmd_fifo
   import micro_motor_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = CMD_W
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   input  logic                   flush,
   output logic [WIDTH-1:0]       head_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level,
   output logic [$clog2(DEPTH):0] next_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full      = (level == LW'(DEPTH));
   assign empty     = (level == '0);
   assign do_push   = push && !full && !flush;
   assign do_pop    = pop && !empty && !flush;
   assign head_data = mem[rd_ptr];

   always_comb begin
      next_level = level;
      if (flush)
         next_level = '0;
      else if (do_push && !do_pop)
         next_level = level + LW'(1);
      else if (do_pop && !do_push)
         next_level = level - LW'(1);
   end

   // Depth is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         level <= next_level;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (do_push)
               wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
               rd_ptr <= rd_ptr + AW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/cmd_arbiter.sv
// Round-robin arbiter feeding a command FIFO that is replayed onto the controller
// port as setup / strobe / gap so the controller latches each command exactly once.
module cmd_arbiter
   import micro_motor_pkg::*;
#(
   parameter int NUM_REQ    = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int LATCH_HIGH = 2,
   parameter int LATCH_GAP  = 2
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [CMD_W*NUM_REQ-1:0]     req_data,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic                         flush,
   output logic [CMD_W-1:0]             cmd_data,
   output logic                         latch_data,
   output logic                         busy,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

   localparam int RR_W    = $clog2(NUM_REQ);
   localparam int LW      = $clog2(FIFO_DEPTH) + 1;
   localparam int CNT_MAX = (LATCH_HIGH > LATCH_GAP) ? LATCH_HIGH : LATCH_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   logic [RR_W-1:0]  rr;
   logic [RR_W-1:0]  grant_idx;
   logic [RR_W-1:0]  sel;
   int               idx;
   logic             transfer;
   logic [CMD_W-1:0] push_data;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CMD_W-1:0] head_data;
   logic [LW-1:0]    next_level;
   strobe_state_t    state;
   strobe_state_t    next_state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] next_cnt;

   // Search from rr upward, wrapping, and grant the first valid requester.
   always_comb begin
      req_ready = '0;
      grant_idx = '0;
      transfer  = 1'b0;
      idx       = 0;
      sel       = '0;
      if (!fifo_full && !flush && !reset) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr) + k;
            if (idx >= NUM_REQ)
               idx = idx - NUM_REQ;
            sel = idx[RR_W-1:0];
            if (!transfer && req_valid[sel]) begin
               transfer       = 1'b1;
               grant_idx      = sel;
               req_ready[sel] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      push_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_idx == RR_W'(k))
            push_data = req_data[k*CMD_W +: CMD_W];
      end
   end

   cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push       (transfer),
      .push_data  (push_data),
      .pop        (pop),
      .flush      (flush),
      .head_data  (head_data),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .level      (fifo_level),
      .next_level (next_level)
   );

   // A flush in IDLE suppresses the pop, so the FSM simply stays idle.
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      pop        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty && !flush) begin
               pop        = 1'b1;
               next_state = ST_SETUP;
            end
         end
         ST_SETUP: begin
            next_state = ST_STROBE;
            next_cnt   = '0;
         end
         ST_STROBE: begin
            if (cnt == CNT_W'(LATCH_HIGH - 1)) begin
               next_state = ST_GAP;
               next_cnt   = '0;
            end else begin
               next_cnt = cnt + CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (cnt == CNT_W'(LATCH_GAP - 1)) begin
               next_state = ST_IDLE;
               next_cnt   = '0;
            end else begin
               next_cnt = cnt + CNT_W'(1);
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         rr         <= '0;
         cmd_data   <= '0;
         latch_data <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= next_state;
         cnt        <= next_cnt;
         latch_data <= (next_state == ST_STROBE);
         busy       <= (next_level != '0) || (next_state != ST_IDLE);
         if (pop)
            cmd_data <= head_data;
         if (transfer)
            rr <= (grant_idx == RR_W'(NUM_REQ - 1)) ? '0 : grant_idx + RR_W'(1);
      end
   end

endmodule

// File: tb/tb_cmd_arbiter.sv
// Bench for cmd_arbiter: a queue-and-countdown reference model tracks grants,
// buffered commands and strobe timing; a second instance covers the short strobe.
module tb_cmd_arbiter;
   import micro_motor_pkg::*;

   localparam int N = 3;
   localparam int D = 4;
   localparam int H = 2;
   localparam int G = 2;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          reset = 1'b1;
   logic          flush = 1'b0;
   logic [N-1:0]  req_valid = '0;
   logic [N-1:0]  req_ready;
   logic [32*N-1:0] req_data = '0;
   logic [31:0]   cmd_data;
   logic          latch_data;
   logic          busy;
   logic [2:0]    fifo_level;

   logic [N-1:0]  req_valid2 = '0;
   logic [N-1:0]  req_ready2;
   logic [32*N-1:0] req_data2 = '0;
   logic          flush2 = 1'b0;
   logic [31:0]   cmd_data2;
   logic          latch_data2;
   logic          busy2;
   logic [2:0]    fifo_level2;

   logic [36:0]   dut_out;
   assign dut_out = {cmd_data, latch_data, busy, fifo_level};

   cmd_arbiter #(.NUM_REQ(N), .FIFO_DEPTH(D), .LATCH_HIGH(H), .LATCH_GAP(G)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .flush(flush), .cmd_data(cmd_data),
      .latch_data(latch_data), .busy(busy), .fifo_level(fifo_level));

   cmd_arbiter #(.NUM_REQ(N), .FIFO_DEPTH(D), .LATCH_HIGH(1), .LATCH_GAP(1)) dut2 (
      .clock(clock), .reset(reset), .req_valid(req_valid2), .req_data(req_data2),
      .req_ready(req_ready2), .flush(flush2), .cmd_data(cmd_data2),
      .latch_data(latch_data2), .busy(busy2), .fifo_level(fifo_level2));

   int checks = 0;
   int errors = 0;

   // Reference model: buffered commands, cycles left for the command on the port,
   // last command presented, and the round-robin start point.
   logic [31:0] mq[$];
   int          m_eng = 0;
   int          m_rr = 0;
   int          m_gidx = -1;
   logic [31:0] m_cmd = '0;
   logic [N-1:0] exp_ready = '0;

   // Requesters: a pending flag and a command each.
   logic [N-1:0] pend = '0;
   logic [31:0]  pdata [N];

   function automatic logic [36:0] exp_out();
      return {m_cmd, (m_eng > G && m_eng <= G + H), (mq.size() > 0 || m_eng > 0),
              3'(mq.size())};
   endfunction

   function automatic logic [31:0] rnd_cmd();
      return make_cmd(2'($urandom), 4'($urandom), 3'($urandom), 23'($urandom));
   endfunction

   task automatic apply();
      req_valid = pend;
      for (int k = 0; k < N; k++) req_data[32*k +: 32] = pdata[k];
      exp_ready = '0;
      m_gidx    = -1;
      if (mq.size() < D && !flush && !reset) begin
         for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (m_gidx < 0 && pend[i]) begin
               m_gidx       = i;
               exp_ready[i] = 1'b1;
            end
         end
      end
   endtask

   task automatic commit();
      bit do_pop;
      if (reset) begin
         mq.delete();
         m_eng = 0;
         m_cmd = '0;
         m_rr  = 0;
      end else begin
         do_pop = (m_eng == 0) && (mq.size() > 0) && !flush;
         if (m_eng > 0) m_eng--;
         if (flush) mq.delete();
         else if (do_pop) begin
            m_cmd = mq.pop_front();
            m_eng = 1 + H + G;
         end
         if (m_gidx >= 0) begin
            mq.push_back(pdata[m_gidx]);
            m_rr = (m_gidx + 1) % N;
            pend[m_gidx] = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      pend[0]  = 1'b1;
      pdata[0] = 32'hC5A0_0011;
      repeat (2) @(posedge clock);
      for (int c = 0; c < 14; c++) begin
         @(negedge clock);
         checks++;
         if (dut_out !== exp_out()) begin
            errors++; $display("FAIL reset_out c%0d got %h exp %h", c, dut_out, exp_out());
         end
         reset = (c < 3);
         flush = 1'b0;
         apply(); #1;
         checks++;
         if (req_ready !== exp_ready) begin
            errors++; $display("FAIL reset_ready c%0d got %b exp %b", c, req_ready, exp_ready);
         end
         commit();
      end
   endtask

   task automatic test_single();
      int highs = 0;
      for (int c = 0; c < 14; c++) begin
         @(negedge clock);
         checks++;
         if (dut_out !== exp_out()) begin
            errors++; $display("FAIL single_out c%0d got %h exp %h", c, dut_out, exp_out());
         end
         if (c == 2) begin
            checks++;
            if (cmd_data !== 32'h8412_00AB) begin
               errors++; $display("FAIL single_cmd got %h exp 841200ab", cmd_data);
            end
         end
         if (latch_data) highs++;
         if (c == 0) begin
            pend[1]  = 1'b1;
            pdata[1] = 32'h8412_00AB;
         end
         apply(); #1;
         checks++;
         if (req_ready !== exp_ready || (c == 0 && req_ready !== 3'b010)) begin
            errors++; $display("FAIL single_ready c%0d got %b exp %b", c, req_ready, exp_ready);
         end
         commit();
      end
      checks++;
      if (highs != 2) begin
         errors++; $display("FAIL single_highs got %0d exp 2", highs);
      end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] last_g = '0;
      for (int c = 0; c < 72; c++) begin
         @(negedge clock);
         checks++;
         if (dut_out !== exp_out()) begin
            errors++; $display("FAIL rr_out c%0d got %h exp %h", c, dut_out, exp_out());
         end
         if (c < 18) begin
            for (int i = 0; i < N; i++) begin
               if (!pend[i]) begin
                  pend[i]  = 1'b1;
                  pdata[i] = rnd_cmd();
               end
            end
         end
         apply(); #1;
         checks++;
         if (req_ready !== exp_ready) begin
            errors++; $display("FAIL rr_ready c%0d got %b exp %b", c, req_ready, exp_ready);
         end
         if (req_ready != '0) begin
            checks++;
            if (req_ready === last_g && (req_valid & ~req_ready) != '0) begin
               errors++; $display("FAIL rr_repeat c%0d got %b exp other than %b", c, req_ready, last_g);
            end
            last_g = req_ready;
         end
         commit();
      end
   endtask

   task automatic test_full_fifo();
      logic [31:0] fv[8];
      logic [31:0] got[$];
      int sent = 0;
      logic prev = 1'b0;
      foreach (fv[k]) fv[k] = rnd_cmd();
      for (int c = 0; c < 64; c++) begin
         @(negedge clock);
         checks++;
         if (dut_out !== exp_out()) begin
            errors++; $display("FAIL full_out c%0d got %h exp %h", c, dut_out, exp_out());
         end
         if (latch_data && !prev) got.push_back(cmd_data);
         prev = latch_data;
         if (!pend[0] && sent < 8) begin
            pend[0]  = 1'b1;
            pdata[0] = fv[sent];
            sent++;
         end
         apply(); #1;
         checks++;
         if (req_ready !== exp_ready || (fifo_level == 3'd4 && req_ready != '0)) begin
            errors++; $display("FAIL full_ready c%0d got %b exp %b", c, req_ready, exp_ready);
         end
         commit();
      end
      checks++;
      if (got.size() != 8) begin
         errors++; $display("FAIL full_count got %0d exp 8", got.size());
      end
      for (int k = 0; k < got.size() && k < 8; k++) begin
         checks++;
         if (got[k] !== fv[k]) begin
            errors++; $display("FAIL full_order %0d got %h exp %h", k, got[k], fv[k]);
         end
      end
   endtask

   task automatic test_flush();
      int rises = 0;
      logic prev = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         checks++;
         if (dut_out !== exp_out()) begin
            errors++; $display("FAIL flush_out c%0d got %h exp %h", c, dut_out, exp_out());
         end
         if (latch_data && !prev) rises++;
         prev = latch_data;
         if (c == 0) begin
            for (int i = 0; i < N; i++) begin
               pend[i]  = 1'b1;
               pdata[i] = rnd_cmd();
            end
         end
         flush = (c == 3);
         apply(); #1;
         checks++;
         if (req_ready !== exp_ready) begin
            errors++; $display("FAIL flush_ready c%0d got %b exp %b", c, req_ready, exp_ready);
         end
         commit();
      end
      flush = 1'b0;
      checks++;
      if (rises != 1 || busy !== 1'b0) begin
         errors++; $display("FAIL flush_strobes got %0d busy %b exp 1 busy 0", rises, busy);
      end
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         checks++;
         if (dut_out !== exp_out() || (c == 4 && dut_out !== '0)) begin
            errors++; $display("FAIL rmid_out c%0d got %h exp %h", c, dut_out, exp_out());
         end
         if (c == 0) begin
            for (int i = 0; i < N; i++) begin
               pend[i]  = 1'b1;
               pdata[i] = rnd_cmd();
            end
         end
         if (c == 4) begin
            pend[1]  = 1'b1;
            pdata[1] = rnd_cmd();
         end
         reset = (c == 3);
         apply(); #1;
         checks++;
         if (req_ready !== exp_ready || (c == 4 && req_ready !== 3'b010)) begin
            errors++; $display("FAIL rmid_ready c%0d got %b exp %b", c, req_ready, exp_ready);
         end
         commit();
      end
      reset = 1'b0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 360; c++) begin
         @(negedge clock);
         checks++;
         if (dut_out !== exp_out()) begin
            errors++; $display("FAIL rand_out c%0d got %h exp %h", c, dut_out, exp_out());
         end
         if (c < 300) begin
            for (int i = 0; i < N; i++) begin
               if (!pend[i] && $urandom_range(0, 3) == 0) begin
                  pend[i]  = 1'b1;
                  pdata[i] = rnd_cmd();
               end
            end
            flush = ($urandom_range(0, 29) == 0);
            reset = ($urandom_range(0, 99) == 0);
         end else begin
            flush = 1'b0;
            reset = 1'b0;
         end
         apply(); #1;
         checks++;
         if (req_ready !== exp_ready) begin
            errors++; $display("FAIL rand_ready c%0d got %b exp %b", c, req_ready, exp_ready);
         end
         commit();
      end
   endtask

   task automatic test_param_sweep();
      logic [31:0] sv[6];
      int sent = 0, rises = 0, highs = 0, last_rise = -1;
      logic prev_latch = 1'b0;
      logic [31:0] prev_cmd = '0;
      foreach (sv[k]) sv[k] = rnd_cmd();
      for (int c = 0; c < 45; c++) begin
         @(negedge clock);
         if (latch_data2) begin
            highs++;
            checks++;
            if (cmd_data2 !== prev_cmd) begin
               errors++; $display("FAIL sweep_stable c%0d got %h exp %h", c, cmd_data2, prev_cmd);
            end
            if (!prev_latch) begin
               checks++;
               if (rises >= 6 || cmd_data2 !== sv[rises]) begin
                  errors++; $display("FAIL sweep_order c%0d got %h strobe %0d", c, cmd_data2, rises);
               end
               if (last_rise >= 0) begin
                  checks++;
                  if (c - last_rise != 4) begin
                     errors++; $display("FAIL sweep_period got %0d exp 4", c - last_rise);
                  end
               end
               last_rise = c;
               rises++;
            end
         end
         prev_latch = latch_data2;
         prev_cmd   = cmd_data2;
         if (sent < 6) begin
            req_valid2        = 3'b001;
            req_data2[31:0]   = sv[sent];
         end else begin
            req_valid2 = '0;
         end
         #1;
         if (req_valid2[0] && req_ready2[0]) sent++;
      end
      checks++;
      if (rises != 6 || highs != 6 || busy2 !== 1'b0 || fifo_level2 !== 3'd0) begin
         errors++;
         $display("FAIL sweep_totals rises %0d highs %0d busy %b level %0d exp 6 6 0 0",
                  rises, highs, busy2, fifo_level2);
      end
   endtask

   initial begin
      foreach (pdata[k]) pdata[k] = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_full_fifo();
      test_flush();
      test_reset_mid();
      test_random();
      test_param_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
